// File: rtl/shared_port_sched_pkg.sv
// shared_port_sched_pkg: FSM state encoding and counter width shared by the port scheduler.
package shared_port_sched_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;
  localparam int CNT_W = 8;
endpackage

// File: rtl/shared_port_sched_rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr, wrapping past N-1 to 0.
module rr_pick #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);
  logic [IW-1:0] hi_idx, lo_idx;
  logic          hi_found;
  // Descending scan leaves the lowest set index overall and the lowest at-or-above ptr.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_idx = IW'(j);
        if (IW'(j) >= ptr) begin
          hi_idx = IW'(j);
          hi_found = 1'b1;
        end
      end
    end
    found = |req;
    idx = hi_found ? hi_idx : lo_idx;
    onehot = found ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/shared_port_sched.sv
// shared_port_sched: round-robin grant of one shared port with burst cap and one-cycle release gap.
// Optional stall-timeout forced release when SHARED_PORT_SCHED_STALL_TIMEOUT_EN is defined.
module shared_port_sched
  import shared_port_sched_pkg::*;
#(
  parameter int N_REQ = 8,
  parameter int MAX_BURST = 16,
  parameter int STALL_LIMIT = 32,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_last,
  input  logic             i_port_rdy,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_grant_idx,
  output logic             o_grant_vld
);
  if (N_REQ < 2 || N_REQ > 32 || MAX_BURST < 1 || MAX_BURST > 255 ||
      STALL_LIMIT < 1 || STALL_LIMIT > 255) begin : g_bad_cfg
    $error("shared_port_sched: parameter out of range");
  end
  state_e           state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d, idx_q, idx_d, pick_idx;
  logic [N_REQ-1:0] grant_q, grant_d, pick_oh;
  logic             vld_q, vld_d, pick_found, beat, rel, stall_rel;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  rr_pick #(.N(N_REQ)) u_pick (
    .req(i_req), .ptr(rr_ptr_q), .onehot(pick_oh), .idx(pick_idx), .found(pick_found)
  );
  assign beat = vld_q & i_req[idx_q] & i_port_rdy;
`ifdef SHARED_PORT_SCHED_STALL_TIMEOUT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             stalling;
  assign stalling = vld_q & i_req[idx_q] & ~i_port_rdy;
  assign stall_rel = stalling & (stall_q == CNT_W'(STALL_LIMIT - 1));
  always_comb begin
    stall_d = stall_q;
    if (state_q != GRANT) stall_d = '0;
    else if (beat) stall_d = '0;
    else if (stalling) stall_d = stall_q + 1'b1;
  end
  always_ff @(posedge i_clk) stall_q <= i_rst ? '0 : stall_d;
`else
  assign stall_rel = 1'b0;
`endif
  assign rel = (beat & (i_last[idx_q] | (beat_cnt_q == CNT_W'(MAX_BURST - 1)))) |
               ~i_req[idx_q] | stall_rel;
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    grant_d = grant_q;
    idx_d = idx_q;
    vld_d = vld_q;
    if (state_q == GRANT) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(beat);
      if (rel) begin
        state_d = GAP;
        grant_d = '0;
        idx_d = '0;
        vld_d = 1'b0;
        rr_ptr_d = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
      end
    end else if (pick_found) begin
      state_d = GRANT;
      grant_d = pick_oh;
      idx_d = pick_idx;
      vld_d = 1'b1;
      beat_cnt_d = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      beat_cnt_q <= '0;
      grant_q <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q <= grant_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
    end
  end
  assign o_grant = grant_q;
  assign o_grant_idx = idx_q;
  assign o_grant_vld = vld_q;
endmodule

// File: tb/tb_shared_port_sched.sv
// tb_shared_port_sched: directed vector table, stall sequence and random run against a tenure-level model.
module tb_shared_port_sched;
  localparam int N = 4, MB = 4, SL = 5;
`ifdef SHARED_PORT_SCHED_STALL_TIMEOUT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  logic         clk = 1'b0, rst = 1'b0, rdy = 1'b0;
  logic [N-1:0] req = '0, last = '0, grant;
  logic [1:0]   gidx;
  logic         gvld;
  int pass_cnt = 0, total = 0;
  int holder = -1, beats = 0, stalls = 0, ptr = 0;

  typedef struct {bit r; logic [N-1:0] q; logic [N-1:0] l; bit d; logic [N-1:0] e;} vec_t;
  vec_t tbl[$];

  shared_port_sched #(.N_REQ(N), .MAX_BURST(MB), .STALL_LIMIT(SL)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_last(last), .i_port_rdy(rdy),
    .o_grant(grant), .o_grant_idx(gidx), .o_grant_vld(gvld)
  );
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_grant(input string tag, input logic [N-1:0] e);
    int ei = 0;
    for (int k = 0; k < N; k++) if (e[k]) ei = k;
    check({tag, ".grant"}, int'(grant), int'(e));
    check({tag, ".idx"}, int'(gidx), ei);
    check({tag, ".vld"}, int'(gvld), int'(e != 0));
  endtask

  // Tenure-level view: one holder or none; any free cycle arbitrates from ptr.
  task automatic model_step(input bit r, input logic [N-1:0] rq, input logic [N-1:0] ls, input bit rd);
    bit bt;
    if (r) begin
      holder = -1; beats = 0; stalls = 0; ptr = 0;
    end else if (holder >= 0) begin
      bt = rq[holder] && rd;
      if (bt) begin beats++; stalls = 0; end
      else if (rq[holder]) stalls++;
      if (!rq[holder] || (bt && (ls[holder] || beats == MB)) || (STALL_EN && stalls == SL)) begin
        ptr = (holder + 1) % N;
        holder = -1;
      end
    end else begin
      for (int k = 0; k < N; k++)
        if (holder < 0 && rq[(ptr + k) % N]) begin
          holder = (ptr + k) % N; beats = 0; stalls = 0;
        end
    end
  endtask

  task automatic cycle(input bit r, input logic [N-1:0] rq, input logic [N-1:0] ls, input bit rd);
    @(negedge clk);
    rst = r; req = rq; last = ls; rdy = rd;
    @(posedge clk);
    model_step(r, rq, ls, rd);
    #1;
  endtask

  task automatic add(input bit r, input logic [N-1:0] q, input logic [N-1:0] l, input bit d, input logic [N-1:0] e);
    vec_t v;
    v.r = r; v.q = q; v.l = l; v.d = d; v.e = e;
    tbl.push_back(v);
  endtask

  initial begin
    logic [N-1:0] rq = '0;
    // single requester, 3 beats, gap, regrant, drop
    add(1, 4'b0000, 4'b0000, 0, 4'b0000);
    add(0, 4'b0010, 4'b0000, 1, 4'b0010);
    add(0, 4'b0010, 4'b0000, 1, 4'b0010);
    add(0, 4'b0010, 4'b0000, 1, 4'b0010);
    add(0, 4'b0010, 4'b0010, 1, 4'b0000);
    add(0, 4'b0010, 4'b0000, 1, 4'b0010);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000);
    // fairness 0,1,2,3,0
    add(1, 4'b0000, 4'b0000, 0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      add(0, 4'b1111, 4'b1111, 1, 4'(1 << (i % 4)));
      add(0, 4'b1111, 4'b1111, 1, 4'b0000);
    end
    // burst cap of 4 then requester 1
    add(1, 4'b0000, 4'b0000, 0, 4'b0000);
    for (int i = 0; i < 4; i++) add(0, 4'b0011, 4'b0000, 1, 4'b0001);
    add(0, 4'b0011, 4'b0000, 1, 4'b0000);
    add(0, 4'b0011, 4'b0000, 1, 4'b0010);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000);
    // wrap from ptr 3 and drop without beat
    add(1, 4'b0000, 4'b0000, 0, 4'b0000);
    add(0, 4'b0100, 4'b0000, 1, 4'b0100);
    add(0, 4'b0100, 4'b0100, 1, 4'b0000);
    add(0, 4'b1001, 4'b0000, 0, 4'b1000);
    add(0, 4'b0001, 4'b0000, 0, 4'b0000);
    add(0, 4'b0001, 4'b0000, 0, 4'b0001);
    add(0, 4'b0000, 4'b0000, 0, 4'b0000);
    // reset mid-tenure, no gap, ptr back at 0
    add(1, 4'b0000, 4'b0000, 0, 4'b0000);
    add(0, 4'b0100, 4'b0000, 1, 4'b0100);
    add(0, 4'b0100, 4'b0000, 1, 4'b0100);
    add(1, 4'b0100, 4'b0000, 1, 4'b0000);
    add(0, 4'b0100, 4'b0000, 1, 4'b0100);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000);
    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].q, tbl[i].l, tbl[i].d);
      check_grant($sformatf("vec%0d", i), tbl[i].e);
    end
    // stall: forced release every SL stalled cycles only with the timeout feature
    cycle(1, 4'b0000, 4'b0000, 0);
    cycle(0, 4'b0001, 4'b0000, 0);
    check_grant("stall_start", 4'b0001);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 4'b0001, 4'b0000, 0);
      check_grant($sformatf("stall%0d", i), (STALL_EN && (i % 6 == 4)) ? 4'b0000 : 4'b0001);
    end
    // random traffic against the model
    cycle(1, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] ls;
      logic [N-1:0] e;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0) rq[k] = ~rq[k];
        ls[k] = ($urandom_range(0, 5) == 0);
      end
      cycle($urandom_range(0, 99) == 0, rq, ls, $urandom_range(0, 3) != 0);
      e = (holder >= 0) ? 4'(1 << holder) : 4'b0000;
      check_grant($sformatf("rand%0d", i), e);
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
